// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the lfsr_prng generator: the structure selector enum,
// the legal parameter ranges and the default 32-bit tap polynomial.
// No ports (package).
// -----------------------------------------------------------------------------
package lfsr_pkg;

  // Feedback structure of the shift register.
  typedef enum logic {
    LFSR_GALOIS    = 1'b0,
    LFSR_FIBONACCI = 1'b1
  } lfsr_mode_e;

  // Legal parameter ranges, checked at elaboration by the top level.
  localparam int LFSR_MIN_WIDTH = 3;
  localparam int LFSR_MAX_WIDTH = 64;
  localparam int LFSR_MIN_STEPS = 1;

  // Default feedback polynomial of the original fixed 32-bit generator.
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

endpackage : lfsr_pkg

// File: rtl/lfsr_prng_if.sv
// -----------------------------------------------------------------------------
// lfsr_prng_if
// Control and output stream of the pseudo-random word generator.
//   en_i         : consumer enables stepping (state held when low)
//   seed_valid_i : load seed_i this cycle
//   seed_i       : new seed value
//   ready_i      : consumer accepts dat_o
//   dat_o        : current LFSR state (registered)
//   valid_o      : dat_o is offered
//   cnt_o        : accepted transfers since reset / last seed load
//   wrap_o       : one-cycle pulse when the state returns to the loaded seed
//   err_o        : sticky zero-seed request flag
// Modports: master = generator side, slave = consumer side.
// -----------------------------------------------------------------------------
interface lfsr_prng_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);

  logic                  en_i;
  logic                  seed_valid_i;
  logic [DATA_WIDTH-1:0] seed_i;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  valid_o;
  logic [CNT_WIDTH-1:0]  cnt_o;
  logic                  wrap_o;
  logic                  err_o;

  modport master (
    input  en_i, seed_valid_i, seed_i, ready_i,
    output dat_o, valid_o, cnt_o, wrap_o, err_o
  );

  modport slave (
    output en_i, seed_valid_i, seed_i, ready_i,
    input  dat_o, valid_o, cnt_o, wrap_o, err_o
  );

endinterface : lfsr_prng_if

// File: rtl/lfsr_step.sv
// -----------------------------------------------------------------------------
// lfsr_step
// One combinational LFSR shift. Chained STEPS times by the top level to advance
// the register several positions per output word.
//   state      : current register value
//   next_state : value after a single shift
// Galois shifts right and folds TAPS in when the bit shifted out is 1.
// Fibonacci shifts left and inserts the parity of the tapped bits.
// -----------------------------------------------------------------------------
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] TAPS       = DATA_WIDTH'(LFSR_TAPS_32),
  parameter lfsr_mode_e            MODE       = LFSR_GALOIS
) (
  input  logic [DATA_WIDTH-1:0] state,
  output logic [DATA_WIDTH-1:0] next_state
);

  if (MODE == LFSR_GALOIS) begin : g_galois
    assign next_state = (state >> 1) ^ (state[0] ? TAPS : '0);
  end else begin : g_fibonacci
    assign next_state = {state[DATA_WIDTH-2:0], ^(state & TAPS)};
  end

endmodule : lfsr_step

// File: rtl/lfsr_prng.sv
// -----------------------------------------------------------------------------
// lfsr_prng
// Parametrised pseudo-random word generator with a valid/ready output stream.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : lfsr_prng_if.master (en/seed/ready in, dat/valid/cnt/wrap/err out)
// Each accepted transfer advances the LFSR by STEPS shifts. A seed load takes
// priority over a transfer in the same cycle; a zero seed is replaced by SEED
// and raises the sticky err flag.
// -----------------------------------------------------------------------------
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] TAPS       = DATA_WIDTH'(LFSR_TAPS_32),
  parameter int                    MODE       = 0,
  parameter int                    STEPS      = 1,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(1),
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  lfsr_prng_if.master bus
);

  // ---------------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------------
  if (DATA_WIDTH < LFSR_MIN_WIDTH || DATA_WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
    $error("lfsr_prng: DATA_WIDTH %0d outside %0d..%0d",
           DATA_WIDTH, LFSR_MIN_WIDTH, LFSR_MAX_WIDTH);
  end
  if (STEPS < LFSR_MIN_STEPS || STEPS > DATA_WIDTH) begin : g_bad_steps
    $error("lfsr_prng: STEPS %0d outside %0d..DATA_WIDTH", STEPS, LFSR_MIN_STEPS);
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_prng: SEED must be nonzero, an all-zero LFSR never leaves zero");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("lfsr_prng: MODE %0d is not 0 (Galois) or 1 (Fibonacci)", MODE);
  end

  localparam lfsr_mode_e MODE_E = (MODE == 1) ? LFSR_FIBONACCI : LFSR_GALOIS;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] state;
  logic [DATA_WIDTH-1:0] wrap_ref;   // last loaded seed, compared for wrap_o
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  valid;
  logic                  wrap;
  logic                  err;

  // ---------------------------------------------------------------------------
  // Multi-step next-state chain: chain[0] is the current state, chain[STEPS]
  // the state after one full output transfer.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] chain [STEPS+1];

  assign chain[0] = state;

  for (genvar i = 0; i < STEPS; i++) begin : g_chain
    lfsr_step #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAPS       (TAPS),
      .MODE       (MODE_E)
    ) u_step (
      .state      (chain[i]),
      .next_state (chain[i+1])
    );
  end

  // ---------------------------------------------------------------------------
  // Load / fire decode
  // ---------------------------------------------------------------------------
  logic                  fire;
  logic                  seed_zero;
  logic [DATA_WIDTH-1:0] load_val;

  assign fire      = valid & bus.ready_i & bus.en_i;
  assign seed_zero = (bus.seed_i == '0);
  assign load_val  = seed_zero ? SEED : bus.seed_i;

  // NOTE: reset is sampled on the clock edge here, so it lives inside the
  // clocked branch rather than in the sensitivity list; every register below
  // uses <= so all of them see pre-edge values of each other.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= SEED;
      wrap_ref <= SEED;
      cnt      <= '0;
      valid    <= 1'b0;
      wrap     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // valid mirrors en one cycle late; a fire needs both, so dropping en
      // stalls the stream immediately even though valid falls a cycle later.
      valid <= bus.en_i;
      wrap  <= 1'b0;
      if (bus.seed_valid_i) begin
        // The handshake on the old word still completes for the consumer,
        // but it neither advances the state nor counts.
        state    <= load_val;
        wrap_ref <= load_val;
        cnt      <= '0;
        if (seed_zero) begin
          err <= 1'b1;
        end
      end else if (fire) begin
        state <= chain[STEPS];
        cnt   <= cnt + CNT_WIDTH'(1);
        wrap  <= (chain[STEPS] == wrap_ref);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.dat_o   = state;
  assign bus.valid_o = valid;
  assign bus.cnt_o   = cnt;
  assign bus.wrap_o  = wrap;
  assign bus.err_o   = err;

endmodule : lfsr_prng

// File: doc/lfsr_prng.md
# lfsr_prng

Parametrised pseudo-random word generator, successor to the fixed 32-bit Galois LFSR. It supports selectable Galois or Fibonacci structure, an arbitrary tap mask, and multiple shifts per output word. It adds runtime seed loading, a valid/ready output stream, a transfer counter and a period-wrap flag. It feeds scramblers, test-pattern generators and randomised arbitration in the common IP library.

## Interface
Parameters:
- DATA_WIDTH, 32: LFSR state and output width; legal range 3..64.
- TAPS, 32'h8020_0003: feedback polynomial mask, DATA_WIDTH bits wide.
- MODE, 0: 0 selects Galois, 1 selects Fibonacci.
- STEPS, 1: shifts applied per output transfer; legal range 1..DATA_WIDTH.
- SEED, 1: reset state and zero-seed substitute; must be nonzero (elaboration assertion).
- CNT_WIDTH, 32: transfer counter width.

Ports (one clock; reset is synchronous and active-high):
- clk_i, input, 1: clock.
- rst_i, input, 1: synchronous active-high reset.
- en_i, input, 1: enables stepping; when low the state is held.
- seed_valid_i, input, 1: load seed_i this cycle.
- seed_i, input, DATA_WIDTH: new seed value.
- dat_o, output, DATA_WIDTH: current state, registered.
- valid_o, output, 1: dat_o is offered to the consumer.
- ready_i, input, 1: consumer accepts dat_o.
- cnt_o, output, CNT_WIDTH: accepted-transfer count since reset or last seed load.
- wrap_o, output, 1: one-cycle pulse when the state returns to the last loaded seed.
- err_o, output, 1: sticky flag, set when a zero seed is requested.

## Operation
- Galois single step, right-shifting: next = (q >> 1) ^ (q[0] ? TAPS : 0).
- Fibonacci single step, left-shifting: fb = ^(q & TAPS); next = {q[DATA_WIDTH-2:0], fb}.
- A transfer ("fire") occurs when valid_o & ready_i & en_i.
  - On fire, the state advances by STEPS chained single steps in one cycle.
  - cnt_o increments by 1 and wraps modulo 2^CNT_WIDTH.
- Seed load (seed_valid_i = 1):
  - Loads the state from seed_i and registers seed_i as the wrap reference.
  - Clears cnt_o.
  - Has priority over a fire in the same cycle; that fire does not advance the state and is not counted.
  - The consumer still sees a completed handshake on the old dat_o.
- Zero-seed guard: if seed_i == 0, SEED is loaded instead, SEED becomes the wrap reference, and err_o is set.
  - err_o stays set until rst_i; no other event clears it.
- wrap_o pulses in the cycle after a fire whose next state equals the wrap reference.
  - A seed load never produces wrap_o.
- en_i low: the state and cnt_o are held, and valid_o drops to 0. Seed loads are still accepted.

## Timing
- Reset values:
  - dat_o = SEED, valid_o = 0, cnt_o = 0, wrap_o = 0, err_o = 0.
  - The wrap reference is SEED.
- valid_o is registered: it equals en_i delayed by one cycle, and is 0 during reset and the first cycle after.
- Latency:
  - After a fire, the new dat_o is visible the next cycle.
  - After a seed load, dat_o equals the seed the next cycle.
- Holding: dat_o is stable while valid_o & ~ready_i.
- Reset mid-stream: on the next edge all outputs take their reset values, regardless of seed_valid_i or a fire in that cycle.
- Combinational depth grows with STEPS. STEPS > 8 is synthesis-checked at the target clock.

## Structure
- Package lfsr_pkg holds:
  - typedef enum lfsr_mode_e with LFSR_GALOIS = 0 and LFSR_FIBONACCI = 1;
  - legal-range localparams for DATA_WIDTH and STEPS;
  - the default tap constant LFSR_TAPS_32.
- Sub-module lfsr_step: purely combinational single step, parametrised by DATA_WIDTH, TAPS and MODE. It is instantiated STEPS times in a generate chain.
- The top level holds:
  - the state, wrap-reference, counter, valid and err registers;
  - the load/fire priority logic.

## Test plan
- Galois, default parameters, SEED = 1, ready_i = 1, en_i = 1: after reset release dat_o reads 0x00000001, 0x80200003, 0xC0300002, 0x60180001 on consecutive cycles; cnt_o reads 0, 1, 2, 3.
- MODE = 1, same TAPS, SEED = 1: dat_o reads 0x00000001, 0x00000003, 0x00000006.
- STEPS = 3, Galois, SEED = 1: the first fire yields 0x60180001 directly.
- Backpressure: hold ready_i = 0 for 5 cycles, then raise it. dat_o is held at 0x80200003 throughout; the next value is 0xC0300002, and cnt_o does not change while stalled.
- Seed load during a fire with seed_i = 0x12345678: the next dat_o is 0x12345678 and cnt_o = 0.
  - Then load seed_i = 0: dat_o = SEED and err_o = 1, and err_o stays 1 until rst_i.
- DATA_WIDTH = 4, TAPS = 4'h9, Galois, SEED = 1, ready_i = 1 continuously: wrap_o pulses every 15 transfers.
  - Asserting rst_i at transfer 7 returns dat_o to 1 and cnt_o to 0 on the next cycle.
